// File: rtl/axi_traffic_master_if.sv
// AXI4 write/read channel bundle used by the traffic master.
// Fixed sideband (size, burst, strobe, id) is tied off outside this bundle.
interface axi_traffic_master_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0] m_axi_awaddr;
    logic [7:0]            m_axi_awlen;
    logic                  m_axi_awvalid;
    logic                  m_axi_awready;
    logic [DATA_WIDTH-1:0] m_axi_wdata;
    logic                  m_axi_wlast;
    logic                  m_axi_wvalid;
    logic                  m_axi_wready;
    logic [1:0]            m_axi_bresp;
    logic                  m_axi_bvalid;
    logic                  m_axi_bready;
    logic [ADDR_WIDTH-1:0] m_axi_araddr;
    logic [7:0]            m_axi_arlen;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;
    logic [DATA_WIDTH-1:0] m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rlast;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;

    modport master (
        output m_axi_awaddr, m_axi_awlen, m_axi_awvalid,
        output m_axi_wdata, m_axi_wlast, m_axi_wvalid,
        output m_axi_bready,
        output m_axi_araddr, m_axi_arlen, m_axi_arvalid,
        output m_axi_rready,
        input  m_axi_awready, m_axi_wready,
        input  m_axi_bresp, m_axi_bvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid
    );

    modport slave (
        input  m_axi_awaddr, m_axi_awlen, m_axi_awvalid,
        input  m_axi_wdata, m_axi_wlast, m_axi_wvalid,
        input  m_axi_bready,
        input  m_axi_araddr, m_axi_arlen, m_axi_arvalid,
        input  m_axi_rready,
        output m_axi_awready, m_axi_wready,
        output m_axi_bresp, m_axi_bvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid
    );
endinterface

// File: rtl/axi_traffic_master.sv
// Write-then-readback AXI burst tester: writes a seed+beat pattern, reads it back
// and counts response, data and rlast-position errors (saturating at 255).
module axi_traffic_master #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [7:0]            len,
    input  logic [31:0]           seed,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            err_cnt,
    axi_traffic_master_if.master  axi
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AW   = 3'd1,
        S_W    = 3'd2,
        S_B    = 3'd3,
        S_AR   = 3'd4,
        S_R    = 3'd5,
        S_DONE = 3'd6
    } state_t;

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {7'd0, b};
        if (sum[8]) begin
            sat_add = 8'hFF;
        end else begin
            sat_add = sum[7:0];
        end
    endfunction

    state_t                state_r, state_next;
    logic [ADDR_WIDTH-1:0] addr_r, addr_next;
    logic [7:0]            len_r, len_next;
    logic [31:0]           seed_r, seed_next;
    logic [7:0]            beat_r, beat_next;
    logic [7:0]            err_cnt_r;
    logic [31:0]           wdata_r;
    logic                  busy_r, done_r, awvalid_r, wvalid_r, wlast_r;
    logic                  bready_r, arvalid_r, rready_r;
    logic                  clr_err_s;
    logic [1:0]            err_inc_s;
    logic [31:0]           rd_word_s;
    logic                  data_bad_s, last_bad_s;

    // Next-state, capture and error-increment decode.
    always_comb begin
        state_next = state_r;
        addr_next  = addr_r;
        len_next   = len_r;
        seed_next  = seed_r;
        beat_next  = beat_r;
        clr_err_s  = 1'b0;
        err_inc_s  = 2'd0;
        rd_word_s  = seed_r + {24'd0, beat_r};
        data_bad_s = (axi.m_axi_rresp != 2'b00) ||
                     (axi.m_axi_rdata != {(DATA_WIDTH/32){rd_word_s}});
        last_bad_s = axi.m_axi_rlast != (beat_r == len_r);
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_next = S_AW;
                    addr_next  = base_addr;
                    len_next   = len;
                    seed_next  = seed;
                    beat_next  = 8'd0;
                    clr_err_s  = 1'b1;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_AW: begin
                if (axi.m_axi_awready) begin
                    state_next = S_W;
                end else begin
                    state_next = S_AW;
                end
            end
            S_W: begin
                if (axi.m_axi_wready && (beat_r == len_r)) begin
                    state_next = S_B;
                    beat_next  = 8'd0;
                end else if (axi.m_axi_wready) begin
                    beat_next = beat_r + 8'd1;
                end else begin
                    beat_next = beat_r;
                end
            end
            S_B: begin
                if (axi.m_axi_bvalid) begin
                    state_next = S_AR;
                    err_inc_s  = (axi.m_axi_bresp != 2'b00) ? 2'd1 : 2'd0;
                end else begin
                    state_next = S_B;
                end
            end
            S_AR: begin
                if (axi.m_axi_arready) begin
                    state_next = S_R;
                end else begin
                    state_next = S_AR;
                end
            end
            S_R: begin
                if (axi.m_axi_rvalid) begin
                    beat_next  = beat_r + 8'd1;
                    err_inc_s  = {1'b0, data_bad_s} + {1'b0, last_bad_s};
                    state_next = axi.m_axi_rlast ? S_DONE : S_R;
                end else begin
                    state_next = S_R;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State, captured parameters and registered outputs derived from next values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= S_IDLE;
            addr_r    <= '0;
            len_r     <= 8'd0;
            seed_r    <= 32'd0;
            beat_r    <= 8'd0;
            err_cnt_r <= 8'd0;
            wdata_r   <= 32'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            wlast_r   <= 1'b0;
            bready_r  <= 1'b0;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
        end else begin
            state_r   <= state_next;
            addr_r    <= addr_next;
            len_r     <= len_next;
            seed_r    <= seed_next;
            beat_r    <= beat_next;
            err_cnt_r <= clr_err_s ? 8'd0 : sat_add(err_cnt_r, err_inc_s);
            wdata_r   <= seed_next + {24'd0, beat_next};
            busy_r    <= (state_next != S_IDLE);
            done_r    <= (state_next == S_DONE);
            awvalid_r <= (state_next == S_AW);
            wvalid_r  <= (state_next == S_W);
            wlast_r   <= (state_next == S_W) && (beat_next == len_next);
            bready_r  <= (state_next == S_B);
            arvalid_r <= (state_next == S_AR);
            rready_r  <= (state_next == S_R);
        end
    end

    assign busy              = busy_r;
    assign done              = done_r;
    assign err_cnt           = err_cnt_r;
    assign axi.m_axi_awaddr  = addr_r;
    assign axi.m_axi_awlen   = len_r;
    assign axi.m_axi_awvalid = awvalid_r;
    assign axi.m_axi_wdata   = {(DATA_WIDTH/32){wdata_r}};
    assign axi.m_axi_wlast   = wlast_r;
    assign axi.m_axi_wvalid  = wvalid_r;
    assign axi.m_axi_bready  = bready_r;
    assign axi.m_axi_araddr  = addr_r;
    assign axi.m_axi_arlen   = len_r;
    assign axi.m_axi_arvalid = arvalid_r;
    assign axi.m_axi_rready  = rready_r;

endmodule

// File: tb/tb_axi_traffic_master.sv
// Randomized bench: echo-memory AXI slave with stalls and injected faults,
// checked against an error-count model derived from the injected faults.
module tb_axi_traffic_master;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int BOUND = 5000;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [7:0]    len;
    logic [31:0]   seed;
    logic          busy, done;
    logic [7:0]    err_cnt;
    int            n_checks = 0;
    int            n_errors = 0;

    axi_traffic_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    axi_traffic_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
        .len(len), .seed(seed), .busy(busy), .done(done), .err_cnt(err_cnt),
        .axi(axi)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pat(input logic [31:0] s, input int i);
        logic [31:0] w;
        w = s + 32'(i);
        return {w, w};
    endfunction

    function automatic logic [63:0] out_vec();
        return 64'({busy, done, err_cnt, axi.m_axi_awvalid, axi.m_axi_wvalid,
                    axi.m_axi_wlast, axi.m_axi_bready, axi.m_axi_arvalid, axi.m_axi_rready});
    endfunction

    function automatic bit rnd_rdy(input bit stall);
        return stall ? ($urandom_range(0, 2) != 0) : 1'b1;
    endfunction

    // One full write/readback sequence. cb/rb: corrupted-data / bad-rresp read beat
    // (-1 none); el: beat carrying an early rlast (-1 = rlast on the true last beat).
    task automatic run_seq(input logic [63:0] a, input logic [7:0] l, input logic [31:0] s,
                           input bit stall, input logic [1:0] br, input int cb,
                           input bit call, input int rb, input int el, input bit poke);
        logic [63:0] mem [256];
        int i, cyc, nb, exp_err;
        bit ph, rdy, poked;
        nb = (el >= 0) ? el + 1 : int'(l) + 1;
        exp_err = (br != 2'b00) ? 1 : 0;
        for (int j = 0; j < nb; j++) begin
            if (call || j == cb || j == rb) exp_err++;
            if ((j == nb - 1) != (j == int'(l))) exp_err++;
        end
        if (exp_err > 255) exp_err = 255;

        @(negedge clk);
        start = 1'b1; base_addr = a; len = l; seed = s;
        @(negedge clk);
        start = 1'b0; base_addr = {$urandom, $urandom}; len = 8'($urandom); seed = $urandom;
        check_eq("aw_latency", 64'(axi.m_axi_awvalid), 64'd1);
        check_eq("busy", 64'(busy), 64'd1);
        check_eq("err_clear", 64'(err_cnt), 64'd0);

        ph = 1'b0; cyc = 0;
        while (!ph && cyc < BOUND) begin
            rdy = rnd_rdy(stall);
            axi.m_axi_awready = rdy;
            if (axi.m_axi_awvalid) begin
                check_eq("awaddr", axi.m_axi_awaddr, a);
                check_eq("awlen", 64'(axi.m_axi_awlen), 64'(l));
                ph = rdy;
            end
            @(negedge clk); cyc++;
        end
        axi.m_axi_awready = 1'b0;
        if (!ph) begin check_eq("aw_timeout", 64'd0, 64'd1); return; end

        check_eq("ready_idle", 64'({axi.m_axi_bready, axi.m_axi_rready}), 64'd0);
        i = 0; cyc = 0; poked = 1'b0;
        while (i <= int'(l) && cyc < BOUND) begin
            start = 1'b0;
            if (poke && i == 1 && !poked) begin
                start = 1'b1; len = ~l; seed = ~s; poked = 1'b1;
            end
            rdy = rnd_rdy(stall);
            axi.m_axi_wready = rdy;
            if (axi.m_axi_wvalid) begin
                check_eq("wdata", axi.m_axi_wdata, pat(s, i));
                check_eq("wlast", 64'(axi.m_axi_wlast), 64'(i == int'(l)));
                if (rdy) begin mem[i] = axi.m_axi_wdata; i++; end
            end
            @(negedge clk); cyc++;
        end
        start = 1'b0; axi.m_axi_wready = 1'b0;
        if (i <= int'(l)) begin check_eq("w_timeout", 64'd0, 64'd1); return; end

        ph = 1'b0; cyc = 0;
        while (!ph && cyc < BOUND) begin
            ph = rnd_rdy(stall);
            axi.m_axi_bvalid = ph;
            axi.m_axi_bresp = br;
            if (ph) check_eq("bready", 64'(axi.m_axi_bready), 64'd1);
            @(negedge clk); cyc++;
        end
        axi.m_axi_bvalid = 1'b0; axi.m_axi_bresp = 2'b00;

        ph = 1'b0; cyc = 0;
        while (!ph && cyc < BOUND) begin
            rdy = rnd_rdy(stall);
            axi.m_axi_arready = rdy;
            if (axi.m_axi_arvalid) begin
                check_eq("araddr", axi.m_axi_araddr, a);
                check_eq("arlen", 64'(axi.m_axi_arlen), 64'(l));
                ph = rdy;
            end
            @(negedge clk); cyc++;
        end
        axi.m_axi_arready = 1'b0;
        if (!ph) begin check_eq("ar_timeout", 64'd0, 64'd1); return; end

        i = 0; cyc = 0;
        while (i < nb && cyc < BOUND) begin
            rdy = rnd_rdy(stall);
            axi.m_axi_rvalid = rdy;
            axi.m_axi_rdata = (call || i == cb) ? (mem[i] ^ 64'h0000_0100_0000_0000) : mem[i];
            axi.m_axi_rresp = (i == rb) ? 2'b10 : 2'b00;
            axi.m_axi_rlast = (i == nb - 1);
            if (rdy) begin
                check_eq("rready", 64'(axi.m_axi_rready), 64'd1);
                i++;
            end
            @(negedge clk); cyc++;
        end
        axi.m_axi_rvalid = 1'b0; axi.m_axi_rlast = 1'b0; axi.m_axi_rresp = 2'b00;

        check_eq("done_pulse", 64'(done), 64'd1);
        check_eq("err_cnt", 64'(err_cnt), 64'(exp_err));
        @(negedge clk);
        check_eq("done_end", 64'({done, busy}), 64'd0);
        check_eq("err_hold", 64'(err_cnt), 64'(exp_err));
    endtask

    initial begin
        int rl, cb, el;
        rstn = 1'b0; start = 1'b0; base_addr = '0; len = 8'd0; seed = 32'd0;
        axi.m_axi_awready = 1'b0; axi.m_axi_wready = 1'b0; axi.m_axi_bvalid = 1'b0;
        axi.m_axi_bresp = 2'b00; axi.m_axi_arready = 1'b0; axi.m_axi_rdata = '0;
        axi.m_axi_rresp = 2'b00; axi.m_axi_rlast = 1'b0; axi.m_axi_rvalid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_outs", out_vec(), 64'd0);
        rstn = 1'b1;

        run_seq({$urandom, $urandom}, 8'd0, 32'h10, 1'b0, 2'b00, -1, 1'b0, -1, -1, 1'b0);
        run_seq({$urandom, $urandom}, 8'd3, $urandom, 1'b1, 2'b00, -1, 1'b0, -1, -1, 1'b0);
        run_seq({$urandom, $urandom}, 8'd2, $urandom, 1'b1, 2'b10, -1, 1'b0, -1, -1, 1'b0);
        run_seq({$urandom, $urandom}, 8'd3, $urandom, 1'b0, 2'b00, 2, 1'b0, -1, -1, 1'b0);
        run_seq({$urandom, $urandom}, 8'd3, $urandom, 1'b1, 2'b00, 2, 1'b0, -1, 2, 1'b0);
        run_seq({$urandom, $urandom}, 8'd5, $urandom, 1'b1, 2'b00, -1, 1'b0, 4, -1, 1'b0);
        run_seq({$urandom, $urandom}, 8'd4, $urandom, 1'b1, 2'b00, -1, 1'b0, -1, -1, 1'b1);
        run_seq({$urandom, $urandom}, 8'd255, $urandom, 1'b0, 2'b11, -1, 1'b1, -1, -1, 1'b0);

        for (int k = 0; k < 6; k++) begin
            rl = int'($urandom_range(0, 15));
            cb = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, rl)) : -1;
            el = (rl > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, rl - 1)) : -1;
            run_seq({$urandom, $urandom}, 8'(rl), $urandom, 1'b1,
                    2'($urandom_range(0, 3)), cb, 1'b0, -1, el, 1'b0);
        end

        // Abort a burst mid-W with reset, then confirm a clean restart.
        @(negedge clk);
        start = 1'b1; base_addr = 64'h1000; len = 8'd3; seed = 32'hA5A5_0000;
        @(negedge clk);
        start = 1'b0; axi.m_axi_awready = 1'b1;
        @(negedge clk);
        axi.m_axi_awready = 1'b0; axi.m_axi_wready = 1'b1;
        @(negedge clk);
        check_eq("mid_w_valid", 64'(axi.m_axi_wvalid), 64'd1);
        rstn = 1'b0;
        #1;
        check_eq("async_rst", out_vec(), 64'd0);
        @(negedge clk);
        check_eq("rst_outs", out_vec(), 64'd0);
        check_eq("rst_wdata", axi.m_axi_wdata, 64'd0);
        axi.m_axi_wready = 1'b0; rstn = 1'b1;
        run_seq(64'h2000, 8'd3, $urandom, 1'b1, 2'b00, -1, 1'b0, -1, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/axi_traffic_master.md
AXI_TRAFFIC_MASTER -- requirements
Module: axi_traffic_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, AXI data width, a multiple of 32.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  single-cycle request to run one test sequence.
REQ-006 SHALL have port base_addr  input  ADDR_WIDTH  burst start address, sampled with start.
REQ-007 SHALL have port len  input  8  burst length minus one (AXI LEN encoding), sampled with start.
REQ-008 SHALL have port seed  input  32  data pattern seed, sampled with start.
REQ-009 SHALL have port busy  output  1  sequence in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at sequence end.
REQ-011 SHALL have port err_cnt  output  8  errors in last sequence, saturating.
REQ-012 SHALL have port m_axi_awaddr  output  ADDR_WIDTH  write address.
REQ-013 SHALL have port m_axi_awlen  output  8  write burst length.
REQ-014 SHALL have port m_axi_awvalid  output  1  write address valid.
REQ-015 SHALL have port m_axi_awready  input  1  write address ready.
REQ-016 SHALL have port m_axi_wdata  output  DATA_WIDTH  write data.
REQ-017 SHALL have port m_axi_wlast  output  1  last write beat.
REQ-018 SHALL have port m_axi_wvalid  output  1  write data valid.
REQ-019 SHALL have port m_axi_wready  input  1  write data ready.
REQ-020 SHALL have port m_axi_bresp  input  2  write response.
REQ-021 SHALL have port m_axi_bvalid  input  1  write response valid.
REQ-022 SHALL have port m_axi_bready  output  1  write response ready.
REQ-023 SHALL have port m_axi_araddr  output  ADDR_WIDTH  read address.
REQ-024 SHALL have port m_axi_arlen  output  8  read burst length.
REQ-025 SHALL have port m_axi_arvalid  output  1  read address valid.
REQ-026 SHALL have port m_axi_arready  input  1  read address ready.
REQ-027 SHALL have port m_axi_rdata  input  DATA_WIDTH  read data.
REQ-028 SHALL have port m_axi_rresp  input  2  read response.
REQ-029 SHALL have port m_axi_rlast  input  1  last read beat.
REQ-030 SHALL have port m_axi_rvalid  input  1  read data valid.
REQ-031 SHALL have port m_axi_rready  output  1  read data ready.
REQ-032 SHALL be integrated with AxSIZE = log2(DATA_WIDTH/8), AxBURST = INCR, WSTRB all ones, ID 0, other sideband 0, tied outside; one transaction outstanding.

Function
REQ-033 SHALL implement FSM IDLE -> AW -> W -> B -> AR -> R -> DONE -> IDLE; busy = 1 in every state except IDLE.
REQ-034 SHALL, in IDLE, capture base_addr/len/seed, clear err_cnt and enter AW on start = 1; start outside IDLE ignored.
REQ-035 SHALL assert awvalid (arvalid) in AW (AR), hold address/len stable until ready, advance on valid&ready; awaddr = araddr = captured base_addr, awlen = arlen = captured len.
REQ-036 SHALL, in W, keep wvalid = 1, beat counter i from 0, wdata = (seed + i) mod 2^32 replicated DATA_WIDTH/32 times, wlast = 1 only when i == len, advance beat on wvalid&wready, enter B after last beat.
REQ-037 SHALL drive bready = 1 only in B; on bvalid: err_cnt += 1 if bresp != 0; enter AR.
REQ-038 SHALL drive rready = 1 only in R; per rvalid beat j: one error if rresp != 0 or rdata != expected pattern for j, one more if rlast != (j == len); on rlast beat enter DONE.
REQ-039 SHALL saturate err_cnt at 255; hold its value until next accepted start.
REQ-040 SHALL pulse done for exactly the one DONE cycle; latency start to first awvalid = 1 cycle.

Reset
REQ-041 SHALL, on rstn = 0, immediately enter IDLE; busy, done, all valid/ready outputs, counters and err_cnt = 0; an in-flight burst is abandoned.

Verification
REQ-042 SHALL pass: len=0, seed=0x10, all readies 1, memory echo -> one W beat 0x00000010_00000010 with wlast, done, err_cnt=0.
REQ-043 SHALL pass: len=3, random ready stalls -> 4 beats seed..seed+3, signals stable under stall, wlast on beat 3 only, err_cnt=0.
REQ-044 SHALL pass: bresp=2'b10, read clean -> err_cnt=1 at done.
REQ-045 SHALL pass: len=3, read beat 2 data corrupted and rlast asserted on beat 3 -> err_cnt=1; rlast on beat 2 instead -> extra error, DONE after beat 2.
REQ-046 SHALL pass: rstn low mid-W burst -> next cycle all outputs 0, state IDLE; new start runs clean sequence.
REQ-047 SHALL pass: start pulsed while busy -> ignored, captured len/seed unchanged.
